// File: rtl/cache_lru_tracker.sv
// cache_lru_tracker: per-set LRU bits plus victim selection/lock for a
// 2-way set-associative cache. A victim chosen at miss time is held stable
// on lru_bit until the fill completes.
module cache_lru_tracker #(
  parameter int NUM_SETS = 8,
  parameter int INDEX_W  = 3
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic [INDEX_W-1:0] index,
  input  logic               valid0,
  input  logic               valid1,
  input  logic               hit_valid,
  input  logic               hit_way,
  input  logic               miss_req,
  input  logic               fill_done,
  output logic               lru_bit,
  output logic               victim_valid,
  output logic [INDEX_W-1:0] victim_index,
  output logic               protocol_err
);

  typedef enum logic {
    IDLE,
    LOCKED
  } state_t;

  state_t               state, state_next;
  logic [NUM_SETS-1:0]  lru;
  logic                 victim_q;
  logic [INDEX_W-1:0]   vidx_q;
  logic                 victim_calc;
  logic                 illegal;

  // State register
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state <= IDLE;
    else        state <= state_next;
  end

  // Next-state logic and illegal-event detection
  always_comb begin
    state_next = state;
    illegal    = 1'b0;
    case (state)
      IDLE: begin
        if (miss_req) state_next = LOCKED;
        if (hit_valid && miss_req) illegal = 1'b1;
        if (fill_done) illegal = 1'b1;
      end
      LOCKED: begin
        if (fill_done) state_next = IDLE;
        if (hit_valid || miss_req) illegal = 1'b1;
      end
      default: state_next = IDLE;
    endcase
  end

  // Victim priority: an invalid way is always preferred over the LRU way
  always_comb begin
    victim_calc = lru[index];
    if (!valid0)      victim_calc = 1'b0;
    else if (!valid1) victim_calc = 1'b1;
  end

  // LRU array: hits in IDLE mark the hit way MRU; fill completion marks the filled way MRU
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      lru <= '0;
    end else if (state == IDLE && hit_valid && !miss_req) begin
      lru[index] <= ~hit_way;
    end else if (state == LOCKED && fill_done) begin
      lru[vidx_q] <= ~victim_q;
    end
  end

  // Victim and index latch, captured only when a miss is accepted
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      victim_q <= 1'b0;
      vidx_q   <= '0;
    end else if (state == IDLE && miss_req) begin
      victim_q <= victim_calc;
      vidx_q   <= index;
    end
  end

  // Sticky protocol error flag
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) protocol_err <= 1'b0;
    else if (illegal) protocol_err <= 1'b1;
  end

  // Outputs depend only on registered state and index, never on miss_req/fill_done
  always_comb begin
    victim_valid = (state == LOCKED);
    lru_bit      = (state == LOCKED) ? victim_q : lru[index];
    victim_index = (state == LOCKED) ? vidx_q : '0;
  end

endmodule

// File: tb/tb_cache_lru_tracker.sv
// Scoreboard bench for cache_lru_tracker: stimulus pushes expected outputs
// from a behavioural model; a monitor pops and compares each cycle.
module tb_cache_lru_tracker;

  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic [2:0] index = '0;
  logic       valid0 = 1'b0, valid1 = 1'b0;
  logic       hit_valid = 1'b0, hit_way = 1'b0;
  logic       miss_req = 1'b0, fill_done = 1'b0;
  logic       lru_bit, victim_valid, protocol_err;
  logic [2:0] victim_index;

  cache_lru_tracker #(.NUM_SETS(8), .INDEX_W(3)) dut (
    .clk(clk), .rst_n(rst_n), .index(index), .valid0(valid0), .valid1(valid1),
    .hit_valid(hit_valid), .hit_way(hit_way), .miss_req(miss_req),
    .fill_done(fill_done), .lru_bit(lru_bit), .victim_valid(victim_valid),
    .victim_index(victim_index), .protocol_err(protocol_err)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic       lb;
    logic       vv;
    logic [2:0] vi;
    logic       pe;
    int         tag;
  } exp_t;

  exp_t exp_q[$];
  int   n_cmp = 0;
  int   n_bad = 0;

  // Reference model: which way is least-recently used per set, and the miss in progress
  int   m_lru[8];
  bit   m_locked;
  int   m_vic;
  int   m_vidx;
  bit   m_err;
  int   step_no = 0;

  task automatic check(input string name, input int act, input int exp, input int tag);
    n_cmp++;
    if (act != exp) begin
      n_bad++;
      $display("FAIL %s step=%0d actual=%0d expected=%0d", name, tag, act, exp);
    end
  endtask

  task automatic model_reset();
    for (int i = 0; i < 8; i++) m_lru[i] = 0;
    m_locked = 0; m_vic = 0; m_vidx = 0; m_err = 0;
  endtask

  // One cycle of stimulus: drive at negedge, advance model, queue expectation
  task automatic step(input int idx, input bit v0, input bit v1, input bit hv,
                      input bit hw, input bit mr, input bit fd);
    exp_t e;
    @(negedge clk);
    index = idx[2:0]; valid0 = v0; valid1 = v1;
    hit_valid = hv; hit_way = hw; miss_req = mr; fill_done = fd;
    if (!m_locked) begin
      if (mr) begin
        if (!v0)      m_vic = 0;
        else if (!v1) m_vic = 1;
        else          m_vic = m_lru[idx];
        m_vidx = idx;
        m_locked = 1;
        if (hv) m_err = 1;
      end else if (hv) begin
        m_lru[idx] = hw ? 0 : 1;
      end
      if (fd) m_err = 1;
    end else begin
      if (hv || mr) m_err = 1;
      if (fd) begin
        m_lru[m_vidx] = (m_vic == 0) ? 1 : 0;
        m_locked = 0;
      end
    end
    e.lb = m_locked ? m_vic[0] : m_lru[idx][0];
    e.vv = m_locked;
    e.vi = m_locked ? m_vidx[2:0] : 3'd0;
    e.pe = m_err;
    e.tag = step_no++;
    exp_q.push_back(e);
  endtask

  task automatic idle(input int idx);
    step(idx, 1, 1, 0, 0, 0, 0);
  endtask

  task automatic drain();
    int budget = 50;
    @(negedge clk);
    hit_valid = 0; miss_req = 0; fill_done = 0;
    while (exp_q.size() != 0 && budget > 0) begin
      @(negedge clk);
      budget--;
    end
    if (exp_q.size() != 0) begin
      n_cmp++; n_bad++;
      $display("FAIL drain_timeout pending=%0d expected=0", exp_q.size());
      exp_q.delete();
    end
  endtask

  // Monitor: outputs settle after each rising edge; compare against queued expectation
  initial begin
    exp_t e;
    forever begin
      @(posedge clk);
      #2;
      if (exp_q.size() != 0) begin
        e = exp_q.pop_front();
        check("lru_bit",      int'(lru_bit),      int'(e.lb), e.tag);
        check("victim_valid", int'(victim_valid), int'(e.vv), e.tag);
        check("victim_index", int'(victim_index), int'(e.vi), e.tag);
        check("protocol_err", int'(protocol_err), int'(e.pe), e.tag);
      end
    end
  end

  initial begin
    model_reset();
    rst_n = 0;
    repeat (3) @(negedge clk);
    #1;
    check("reset_lru_bit", int'(lru_bit), 0, -1);
    check("reset_victim_valid", int'(victim_valid), 0, -1);
    check("reset_protocol_err", int'(protocol_err), 0, -1);
    rst_n = 1;

    // Idle sweep after reset
    for (int i = 0; i < 8; i++) idle(i);

    // Hit updates on set 3, then confirm other sets untouched
    step(3, 1, 1, 1, 0, 0, 0);
    idle(3);
    step(3, 1, 1, 1, 1, 0, 0);
    for (int i = 0; i < 8; i++) idle(i);

    // Invalid way 1 preferred over lru
    step(5, 1, 0, 0, 0, 1, 0);
    idle(5);
    step(5, 1, 0, 0, 0, 0, 1);
    idle(5);

    // Victim lock stability while index moves and hits arrive
    step(2, 1, 1, 1, 0, 0, 0);
    step(2, 1, 1, 0, 0, 1, 0);
    step(6, 1, 1, 1, 0, 0, 0);
    step(6, 0, 0, 0, 0, 0, 0);
    step(6, 1, 1, 1, 1, 0, 0);
    step(6, 1, 1, 0, 0, 0, 0);
    step(2, 1, 1, 0, 0, 0, 1);
    idle(2);
    idle(6);

    // Simultaneous hit and miss in IDLE: miss wins
    step(4, 1, 1, 1, 0, 1, 0);
    step(4, 1, 1, 0, 0, 0, 1);
    idle(4);

    // Asynchronous reset during a locked fill
    step(1, 1, 1, 1, 1, 0, 0);
    step(1, 1, 1, 0, 0, 1, 0);
    idle(7);
    drain();
    #3;
    rst_n = 0;
    #1;
    check("async_rst_victim_valid", int'(victim_valid), 0, -2);
    check("async_rst_lru_bit", int'(lru_bit), 0, -2);
    check("async_rst_victim_index", int'(victim_index), 0, -2);
    check("async_rst_protocol_err", int'(protocol_err), 0, -2);
    model_reset();
    @(negedge clk);
    rst_n = 1;
    idle(1);

    // Randomized traffic, mostly legal with occasional protocol violations
    for (int i = 0; i < 600; i++) begin
      int idx = $urandom_range(0, 7);
      bit v0 = ($urandom_range(0, 3) != 0);
      bit v1 = ($urandom_range(0, 3) != 0);
      bit hv = 0, hw = $urandom_range(0, 1), mr = 0, fd = 0;
      int r = $urandom_range(0, 99);
      if (!m_locked) begin
        if (r < 45) hv = 1;
        else if (r < 70) mr = 1;
        if (r == 99) begin hv = 1; mr = 1; end
        if (r == 98) fd = 1;
      end else begin
        if (r < 35) fd = 1;
        if (r > 96) hv = 1;
        if (r == 96) mr = 1;
      end
      step(idx, v0, v1, hv, hw, mr, fd);
    end
    drain();

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
